// File: rtl/debug_loader_if.sv
// Byte-stream host link plus core debug/programming port of the debug loader.
// master = loader side; slave = host UART and core side.
interface debug_loader_if #(
   parameter int AddrWidth = 13
);
   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 debug;
   logic [AddrWidth-1:0] debug_addr;
   logic [7:0]           debug_data;
   logic                 debug_imem;
   logic                 debug_full_reset;
   logic                 core_reset;
   logic                 busy;

   modport master (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid, debug, debug_addr, debug_data,
             debug_imem, debug_full_reset, core_reset, busy
   );

   modport slave (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid, debug, debug_addr, debug_data,
             debug_imem, debug_full_reset, core_reset, busy
   );
endinterface

// File: rtl/debug_loader.sv
// Host command parser driving the core debug port; one status byte per command, 2 cycles/data byte.
// rx stalls (rx_ready=0) in WR/CLR/RESP; status byte held on tx until tx_ready.
module debug_loader #(
   parameter int AddrWidth     = 13,
   parameter int IMemBytes     = 4096,
   parameter int DMemBytes     = 4096,
   parameter int ClearCycles   = 4,
   parameter int TimeoutCycles = 1000000,
   parameter bit BootRun       = 1'b0
) (
   input logic            clk,
   input logic            rst_n,
   debug_loader_if.master bus
);

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_RUN   = 8'h02;
   localparam logic [7:0] CMD_HALT  = 8'h03;
   localparam logic [7:0] CMD_CLEAR = 8'h04;
   localparam logic [7:0] ACK       = 8'h79;
   localparam logic [7:0] NACK      = 8'h1F;

   localparam int CW = (ClearCycles > 1) ? $clog2(ClearCycles) : 1;
   localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CW-1:0] CLR_LAST = CW'(ClearCycles - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TimeoutCycles - 1);
   localparam logic [16:0]   MEM_TOP  = 17'(IMemBytes + DMemBytes);

   typedef enum logic [3:0] {
      S_BOOT, S_IDLE, S_A0, S_A1, S_L0, S_L1, S_DATA, S_WR, S_CLR, S_RESP
   } state_t;

   state_t               state, state_n;
   logic [15:0]          addr, addr_n;
   logic [7:0]           len_lo, len_lo_n;
   logic [AddrWidth-1:0] cur, cur_n;
   logic [15:0]          rem, rem_n;
   logic [7:0]           wr_byte, wr_byte_n;
   logic                 err, err_n;
   logic [7:0]           status, status_n;
   logic                 core_rst, core_rst_n;
   logic [TW-1:0]        idle_cnt, idle_cnt_n;
   logic [CW-1:0]        clr_cnt, clr_cnt_n;

   logic                 rx_ready;
   logic                 rx_fire;
   logic                 timed;
   logic [15:0]          len_full;
   logic                 range_err;

   assign rx_ready  = state inside {S_IDLE, S_A0, S_A1, S_L0, S_L1, S_DATA};
   assign rx_fire   = bus.rx_valid & rx_ready;
   assign timed     = state inside {S_A0, S_A1, S_L0, S_L1, S_DATA};
   assign len_full  = {bus.rx_data, len_lo};
   // 17-bit sum so a region running past the top of the address space cannot wrap into range.
   assign range_err = ({1'b0, addr} + {1'b0, len_full}) > MEM_TOP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_BOOT;
         addr     <= '0;
         len_lo   <= '0;
         cur      <= '0;
         rem      <= '0;
         wr_byte  <= '0;
         err      <= 1'b0;
         status   <= '0;
         core_rst <= ~BootRun;
         idle_cnt <= '0;
         clr_cnt  <= '0;
      end else begin
         state    <= state_n;
         addr     <= addr_n;
         len_lo   <= len_lo_n;
         cur      <= cur_n;
         rem      <= rem_n;
         wr_byte  <= wr_byte_n;
         err      <= err_n;
         status   <= status_n;
         core_rst <= core_rst_n;
         idle_cnt <= idle_cnt_n;
         clr_cnt  <= clr_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      addr_n     = addr;
      len_lo_n   = len_lo;
      cur_n      = cur;
      rem_n      = rem;
      wr_byte_n  = wr_byte;
      err_n      = err;
      status_n   = status;
      core_rst_n = core_rst;
      idle_cnt_n = '0;
      clr_cnt_n  = clr_cnt;

      // Inter-byte timeout only fires on cycles without a handshake, so it never races the case below.
      if (timed && !rx_fire) begin
         if (idle_cnt == TO_LAST) begin
            state_n  = S_RESP;
            status_n = NACK;
         end else begin
            idle_cnt_n = idle_cnt + TW'(1);
         end
      end

      case (state)
         S_BOOT: state_n = S_IDLE;
         S_IDLE: begin
            if (rx_fire) begin
               case (bus.rx_data)
                  CMD_WRITE: begin
                     state_n    = S_A0;
                     core_rst_n = 1'b1;
                     err_n      = 1'b0;
                  end
                  CMD_RUN: begin
                     state_n    = S_RESP;
                     status_n   = ACK;
                     core_rst_n = 1'b0;
                  end
                  CMD_HALT: begin
                     state_n    = S_RESP;
                     status_n   = ACK;
                     core_rst_n = 1'b1;
                  end
                  CMD_CLEAR: begin
                     state_n    = S_CLR;
                     core_rst_n = 1'b1;
                     clr_cnt_n  = '0;
                  end
                  default: begin
                     state_n  = S_RESP;
                     status_n = NACK;
                  end
               endcase
            end
         end
         S_A0: if (rx_fire) begin
            addr_n[7:0] = bus.rx_data;
            state_n     = S_A1;
         end
         S_A1: if (rx_fire) begin
            addr_n[15:8] = bus.rx_data;
            state_n      = S_L0;
         end
         S_L0: if (rx_fire) begin
            len_lo_n = bus.rx_data;
            state_n  = S_L1;
         end
         S_L1: if (rx_fire) begin
            err_n = range_err;
            cur_n = addr[AddrWidth-1:0];
            rem_n = len_full;
            if (len_full == 16'd0) begin
               state_n  = S_RESP;
               status_n = range_err ? NACK : ACK;
            end else begin
               state_n = S_DATA;
            end
         end
         S_DATA: if (rx_fire) begin
            if (err) begin
               // Out-of-range frame: drain the payload without touching memory.
               rem_n = rem - 16'd1;
               if (rem == 16'd1) begin
                  state_n  = S_RESP;
                  status_n = NACK;
               end
            end else begin
               wr_byte_n = bus.rx_data;
               state_n   = S_WR;
            end
         end
         S_WR: begin
            cur_n = cur + AddrWidth'(1);
            rem_n = rem - 16'd1;
            if (rem == 16'd1) begin
               state_n  = S_RESP;
               status_n = ACK;
            end else begin
               state_n = S_DATA;
            end
         end
         S_CLR: begin
            if (clr_cnt == CLR_LAST) begin
               state_n  = S_RESP;
               status_n = ACK;
            end else begin
               clr_cnt_n = clr_cnt + CW'(1);
            end
         end
         S_RESP: if (bus.tx_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.rx_ready         = rx_ready;
   assign bus.tx_valid         = (state == S_RESP);
   assign bus.tx_data          = (state == S_RESP) ? status : 8'h00;
   assign bus.debug            = (state == S_WR);
   assign bus.debug_addr       = (state == S_WR) ? cur : '0;
   assign bus.debug_data       = (state == S_WR) ? wr_byte : 8'h00;
   assign bus.debug_imem       = (state == S_WR) && (32'(cur) < IMemBytes);
   assign bus.debug_full_reset = (state == S_CLR);
   assign bus.core_reset       = core_rst;
   assign bus.busy             = !(state inside {S_BOOT, S_IDLE});

endmodule
